// File: rtl/ps2_ascii_decoder_if.sv
// Scan-byte input and ASCII output bundle for ps2_ascii_decoder.
// caps_on exists only when PS2_CAPS_LOCK_EN is defined.
interface ps2_ascii_decoder_if;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic [7:0] ASCII;
  logic       ASCII_ready;
  logic       shift_active;
`ifdef PS2_CAPS_LOCK_EN
  logic       caps_on;

  modport master (
    output scan_code, scan_ready,
    input  ASCII, ASCII_ready, shift_active, caps_on
  );
  modport slave (
    input  scan_code, scan_ready,
    output ASCII, ASCII_ready, shift_active, caps_on
  );
`else
  modport master (
    output scan_code, scan_ready,
    input  ASCII, ASCII_ready, shift_active
  );
  modport slave (
    input  scan_code, scan_ready,
    output ASCII, ASCII_ready, shift_active
  );
`endif
endinterface

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan byte to ASCII decoder with shift tracking.
// Optional caps-lock support is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_ascii_decoder (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_ascii_decoder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e      state_q;
  logic        lshift_q;
  logic        rshift_q;
  logic [7:0]  ascii_q;
  logic        ascii_ready_q;
`ifdef PS2_CAPS_LOCK_EN
  logic        caps_q;
  logic        caps_held_q;
`endif

  // Table entry: {hit, is_letter, unshifted char, shifted char}
  logic [17:0] ent;
  logic        map_hit;
  logic        is_letter;
  logic [7:0]  lower_ch;
  logic [7:0]  upper_ch;
  logic        shift_now;
  logic        upper_sel;
  logic [7:0]  out_ch;

  always_comb begin
    ent = '0;
    case (bus.scan_code)
      8'h1C: ent = {2'b11, "a", "A"};
      8'h32: ent = {2'b11, "b", "B"};
      8'h21: ent = {2'b11, "c", "C"};
      8'h23: ent = {2'b11, "d", "D"};
      8'h24: ent = {2'b11, "e", "E"};
      8'h2B: ent = {2'b11, "f", "F"};
      8'h34: ent = {2'b11, "g", "G"};
      8'h33: ent = {2'b11, "h", "H"};
      8'h43: ent = {2'b11, "i", "I"};
      8'h3B: ent = {2'b11, "j", "J"};
      8'h42: ent = {2'b11, "k", "K"};
      8'h4B: ent = {2'b11, "l", "L"};
      8'h3A: ent = {2'b11, "m", "M"};
      8'h31: ent = {2'b11, "n", "N"};
      8'h44: ent = {2'b11, "o", "O"};
      8'h4D: ent = {2'b11, "p", "P"};
      8'h15: ent = {2'b11, "q", "Q"};
      8'h2D: ent = {2'b11, "r", "R"};
      8'h1B: ent = {2'b11, "s", "S"};
      8'h2C: ent = {2'b11, "t", "T"};
      8'h3C: ent = {2'b11, "u", "U"};
      8'h2A: ent = {2'b11, "v", "V"};
      8'h1D: ent = {2'b11, "w", "W"};
      8'h22: ent = {2'b11, "x", "X"};
      8'h35: ent = {2'b11, "y", "Y"};
      8'h1A: ent = {2'b11, "z", "Z"};
      8'h45: ent = {2'b10, "0", ")"};
      8'h16: ent = {2'b10, "1", "!"};
      8'h1E: ent = {2'b10, "2", "@"};
      8'h26: ent = {2'b10, "3", "#"};
      8'h25: ent = {2'b10, "4", "$"};
      8'h2E: ent = {2'b10, "5", "%"};
      8'h36: ent = {2'b10, "6", "^"};
      8'h3D: ent = {2'b10, "7", "&"};
      8'h3E: ent = {2'b10, "8", "*"};
      8'h46: ent = {2'b10, "9", "("};
      8'h4E: ent = {2'b10, "-", "_"};
      8'h55: ent = {2'b10, "=", "+"};
      8'h54: ent = {2'b10, "[", "{"};
      8'h5B: ent = {2'b10, "]", "}"};
      8'h4C: ent = {2'b10, ";", ":"};
      8'h52: ent = {2'b10, "'", "\""};
      8'h41: ent = {2'b10, ",", "<"};
      8'h49: ent = {2'b10, ".", ">"};
      8'h4A: ent = {2'b10, "/", "?"};
      8'h0E: ent = {2'b10, 8'h60, "~"};
      8'h5D: ent = {2'b10, "\\", "|"};
      8'h29: ent = {2'b10, 8'h20, 8'h20};
      8'h5A: ent = {2'b10, 8'h0D, 8'h0D};
      8'h66: ent = {2'b10, 8'h08, 8'h08};
      default: ent = '0;
    endcase
  end

  assign map_hit   = ent[17];
  assign is_letter = ent[16];
  assign lower_ch  = ent[15:8];
  assign upper_ch  = ent[7:0];
  assign shift_now = lshift_q | rshift_q;

`ifdef PS2_CAPS_LOCK_EN
  // Caps lock inverts case for letters only.
  assign upper_sel = is_letter ? (shift_now ^ caps_q) : shift_now;
`else
  assign upper_sel = shift_now;
`endif
  assign out_ch = upper_sel ? upper_ch : lower_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      ascii_q       <= 8'h00;
      ascii_ready_q <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps_q        <= 1'b0;
      caps_held_q   <= 1'b0;
`endif
    end else begin
      ascii_ready_q <= 1'b0;
      if (bus.scan_ready) begin
        case (state_q)
          StIdle: begin
            if (bus.scan_code == 8'hF0) begin
              state_q <= StBrk;
            end else if (bus.scan_code == 8'hE0) begin
              state_q <= StExt;
            end else if (bus.scan_code == 8'h12) begin
              lshift_q <= 1'b1;
            end else if (bus.scan_code == 8'h59) begin
              rshift_q <= 1'b1;
`ifdef PS2_CAPS_LOCK_EN
            end else if (bus.scan_code == 8'h58) begin
              // Toggle only on the first make so typematic repeats are ignored.
              if (!caps_held_q) begin
                caps_q <= ~caps_q;
              end
              caps_held_q <= 1'b1;
`endif
            end else if (map_hit) begin
              ascii_q       <= out_ch;
              ascii_ready_q <= 1'b1;
            end
          end
          StBrk: begin
            if (bus.scan_code == 8'h12) begin
              lshift_q <= 1'b0;
            end else if (bus.scan_code == 8'h59) begin
              rshift_q <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
            end else if (bus.scan_code == 8'h58) begin
              caps_held_q <= 1'b0;
`endif
            end
            state_q <= StIdle;
          end
          StExt: begin
            state_q <= (bus.scan_code == 8'hF0) ? StExtBrk : StIdle;
          end
          StExtBrk: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.ASCII        = ascii_q;
  assign bus.ASCII_ready  = ascii_ready_q;
  assign bus.shift_active = shift_now;
`ifdef PS2_CAPS_LOCK_EN
  assign bus.caps_on      = caps_q;
`endif

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: directed sequences plus random scan bytes
// checked against a frame-level keyboard model.
module tb_ps2_ascii_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_ascii_decoder_if bus ();

  ps2_ascii_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] ch;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] last_ascii = 8'h00;

  // Reference tables
  logic [7:0] lc_tab[256];
  logic [7:0] uc_tab[256];
  bit         mapped[256];
  bit         letter[256];
  logic [7:0] all_codes[50];

  // Keyboard model: pending prefix bytes, held modifiers
  logic [7:0] pend[$];
  bit         lsh, rsh, caps, held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic build_tables();
    logic [7:0] codes[47] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
      8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
      8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E, 8'h5D};
    string lo = "abcdefghijklmnopqrstuvwxyz0123456789-=[];',./ \\";
    string hi = "ABCDEFGHIJKLMNOPQRSTUVWXYZ)!@#$%^&*(_+{}:\"<>?~|";
    logic [7:0] ctl_code[3] = '{8'h29, 8'h5A, 8'h66};
    logic [7:0] ctl_char[3] = '{8'h20, 8'h0D, 8'h08};
    for (int i = 0; i < 256; i++) begin
      mapped[i] = 1'b0;
      letter[i] = 1'b0;
      lc_tab[i] = 8'h00;
      uc_tab[i] = 8'h00;
    end
    for (int i = 0; i < 47; i++) begin
      mapped[codes[i]] = 1'b1;
      letter[codes[i]] = (i < 26);
      lc_tab[codes[i]] = lo[i];
      uc_tab[codes[i]] = hi[i];
      all_codes[i]     = codes[i];
    end
    lc_tab[8'h0E] = 8'h60;
    for (int i = 0; i < 3; i++) begin
      mapped[ctl_code[i]] = 1'b1;
      lc_tab[ctl_code[i]] = ctl_char[i];
      uc_tab[ctl_code[i]] = ctl_char[i];
      all_codes[47 + i]   = ctl_code[i];
    end
  endtask

  // Interpret a byte as part of a key frame: [E0] [F0] code.
  task automatic model_byte(input logic [7:0] b);
    bit ext, brk, up;
    exp_t e;
    if (pend.size() == 0 && (b == 8'hF0 || b == 8'hE0)) begin
      pend.push_back(b);
      return;
    end
    if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
      pend.push_back(b);
      return;
    end
    ext = (pend.size() > 0) && (pend[0] == 8'hE0);
    brk = !ext && (pend.size() > 0);
    pend.delete();
    if (ext) return;
    if (brk) begin
      if (b == 8'h12) lsh = 1'b0;
      if (b == 8'h59) rsh = 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      if (b == 8'h58) held = 1'b0;
`endif
      return;
    end
    if (b == 8'h12) begin
      lsh = 1'b1;
      return;
    end
    if (b == 8'h59) begin
      rsh = 1'b1;
      return;
    end
`ifdef PS2_CAPS_LOCK_EN
    if (b == 8'h58) begin
      if (!held) caps = !caps;
      held = 1'b1;
      return;
    end
`endif
    if (mapped[b]) begin
      up = letter[b] ? ((lsh | rsh) ^ caps) : (lsh | rsh);
      e.cyc = cyc + 1;
      e.ch  = up ? uc_tab[b] : lc_tab[b];
      exp_q.push_back(e);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    miscompares++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Call at a falling edge; consumes exactly one cycle.
  task automatic send(input logic [7:0] b);
    bus.scan_code  = b;
    bus.scan_ready = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    vectors++;
    if (bus.shift_active !== (lsh | rsh)) fail("shift_active", bus.shift_active, lsh | rsh);
`ifdef PS2_CAPS_LOCK_EN
    vectors++;
    if (bus.caps_on !== caps) fail("caps_on", bus.caps_on, caps);
`endif
    @(negedge clk);
    bus.scan_ready = 1'b0;
    bus.scan_code  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    pend.delete();
    exp_q.delete();
    lsh = 1'b0;
    rsh = 1'b0;
    caps = 1'b0;
    held = 1'b0;
    last_ascii = 8'h00;
    repeat (n) @(negedge clk);
    vectors++;
    if (bus.ASCII !== 8'h00) fail("reset_ascii", bus.ASCII, 0);
    vectors++;
    if (bus.ASCII_ready !== 1'b0) fail("reset_ready", bus.ASCII_ready, 0);
    vectors++;
    if (bus.shift_active !== 1'b0) fail("reset_shift", bus.shift_active, 0);
`ifdef PS2_CAPS_LOCK_EN
    vectors++;
    if (bus.caps_on !== 1'b0) fail("reset_caps_on", bus.caps_on, 0);
`endif
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every pulse, checks ASCII holds otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        vectors++;
        fail("missing_pulse", 0, exp_q[0].ch);
        last_ascii = exp_q[0].ch;
        void'(exp_q.pop_front());
      end
      vectors++;
      if (bus.ASCII_ready === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          fail("spurious_pulse", bus.ASCII, 0);
        end else begin
          if (bus.ASCII !== exp_q[0].ch) fail("ascii_value", bus.ASCII, exp_q[0].ch);
          last_ascii = exp_q[0].ch;
          void'(exp_q.pop_front());
        end
      end else if (bus.ASCII_ready !== 1'b0 || bus.ASCII !== last_ascii) begin
        fail("ascii_hold", bus.ASCII, last_ascii);
      end
    end
  end

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    if (r < 50) return all_codes[$urandom_range(0, 49)];
    if (r < 60) return 8'hF0;
    if (r < 68) return 8'hE0;
    if (r < 74) return 8'h12;
    if (r < 80) return 8'h59;
    if (r < 84) return 8'h58;
    return 8'($urandom);
  endfunction

  initial begin
    bus.scan_code  = 8'h00;
    bus.scan_ready = 1'b0;
    build_tables();
    @(negedge clk);
    apply_reset(2);
    idle(1);

    // Single make, then shift/unshift, then extended keys
    send(8'h1C);
    idle(2);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    idle(2);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h1C);
    idle(2);
    // Back-to-back mapped bytes
    send(8'h16); send(8'h5A); send(8'h29); send(8'h66);
    idle(2);
    // Right shift, shifted punctuation, typematic repeat
    send(8'h59); send(8'h16); send(8'h16); send(8'h52); send(8'hF0); send(8'h59);
    send(8'h5D);
    idle(2);
    // Reset in the middle of a break sequence
    send(8'hF0);
    idle(1);
    apply_reset(2);
    send(8'h1C);
    idle(2);
`ifdef PS2_CAPS_LOCK_EN
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'h16);
    idle(2);
    apply_reset(1);
`endif

    for (int i = 0; i < 3000; i++) begin
      send(pick());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i % 1000 == 999) begin
        idle(2);
        apply_reset($urandom_range(1, 3));
      end
    end

    idle(4);
    vectors++;
    if (exp_q.size() != 0) fail("leftover_expected", 0, exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
PS2_ASCII_DECODER -- requirements
Module: ps2_ascii_decoder

Interface
- REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
- REQ-002 The block SHALL have scan_code input 8: one PS/2 set-2 byte from the receiver.
- REQ-003 The block SHALL have scan_ready input 1: a one-cycle pulse that qualifies scan_code.
- REQ-004 The block SHALL have ASCII output 8: the decoded character, registered.
- REQ-005 The block SHALL have ASCII_ready output 1: a one-cycle pulse that qualifies ASCII and writes directly into the downstream character FIFO.
- REQ-006 The block SHALL have shift_active output 1: the OR of the left-shift and right-shift held flags.

Function
- REQ-007 The block SHALL process scan_code only in cycles where scan_ready=1; in all other cycles, state and outputs SHALL hold, except that ASCII_ready SHALL return to 0.
- REQ-008 The FSM SHALL have states IDLE, BRK, EXT and EXT_BRK.
- REQ-009 In IDLE: byte 0xF0 -> BRK; byte 0xE0 -> EXT; any other byte is a make code, handled per REQ-012..015, and the state SHALL remain IDLE.
- REQ-010 In BRK, the byte is a break code: 0x12 clears lshift, 0x59 clears rshift, 0x58 clears caps_held, all other bytes are ignored; the next state SHALL be IDLE; no output SHALL be produced.
- REQ-011 In EXT: 0xF0 -> EXT_BRK; any other byte -> IDLE. In EXT_BRK: any byte -> IDLE. Extended keys SHALL never produce output.
- REQ-012 A make code of 0x12 or 0x59 SHALL set lshift or rshift respectively and SHALL produce no output.
- REQ-013 Other make codes SHALL be looked up in the set-2 table covering: a-z; 0-9; space 0x29->0x20; Enter 0x5A->0x0D; Backspace 0x66->0x08; and - = [ ] ; ' , . / ` \.
- REQ-014 A mapped make code SHALL load ASCII and pulse ASCII_ready for exactly one cycle, in the clock cycle after the scan_ready sample (latency 1).
- REQ-015 Unmapped make codes SHALL produce no pulse and SHALL leave ASCII unchanged.
- REQ-016 When shift_active=1, letters SHALL map to upper case and digits/punctuation to their US shifted symbols (e.g. 0x16 -> '!' 0x21).
- REQ-017 Typematic repeats, i.e. repeated make codes without an intervening break, SHALL each produce an output pulse.
- REQ-018 Back-to-back scan_ready pulses on consecutive cycles SHALL each be consumed; there SHALL be no back-pressure and no dropped bytes.
- REQ-019 ASCII SHALL hold its last value between pulses.

Reset
- REQ-020 While rst_n=0, the block SHALL hold: state=IDLE, ASCII=0x00, ASCII_ready=0, lshift=rshift=0, caps=caps_held=0, shift_active=0.
- REQ-021 Assertion of rst_n mid-sequence (e.g. after 0xF0) SHALL discard the partial sequence; the first byte after release SHALL be treated as starting in IDLE.

Configuration
- REQ-022 With PS2_CAPS_LOCK_EN defined, a 0x58 make code SHALL toggle caps only when caps_held=0, and SHALL then set caps_held, so that typematic repeats do not toggle.
- REQ-023 With PS2_CAPS_LOCK_EN defined, letter case SHALL equal shift_active XOR caps; caps SHALL not affect non-letters.
- REQ-024 With PS2_CAPS_LOCK_EN defined, an extra output caps_on (1 bit) SHALL reflect caps and SHALL reset to 0.
- REQ-025 Without PS2_CAPS_LOCK_EN, 0x58 SHALL be treated as unmapped; caps logic and the caps_on port SHALL be absent; case SHALL depend on shift_active only.

Verification
- REQ-026 Byte 0x1C -> one cycle later ASCII=0x61 and ASCII_ready=1 for exactly one cycle.
- REQ-027 Sequence 0x12, 0x1C, 0xF0 0x12, 0x1C -> outputs 0x41 then 0x61; shift_active is 1 between the 0x12 make and its break.
- REQ-028 Sequence 0xE0 0x75, 0xE0 0xF0 0x75, 0xF0 0x1C -> no ASCII_ready pulses; state returns to IDLE.
- REQ-029 Bytes 0x16, 0x5A, 0x29, 0x66 on four consecutive cycles -> four consecutive pulses carrying 0x31, 0x0D, 0x20, 0x08.
- REQ-030 Byte 0xF0, then rst_n low for 2 cycles, then byte 0x1C -> output 0x61; the 0x1C is not treated as a break.
- REQ-031 With PS2_CAPS_LOCK_EN defined: sequence 0x58, 0x58, 0xF0 0x58, 0x1C, 0x12, 0x1C -> caps_on=1, outputs 0x41 then 0x61.
